// File: rtl/paddle_move_ctrl.sv
// Paddle move controller: turns player buttons (or the CPU tracker for player 2)
// into registered per-tick inc/dec commands for the paddle position datapath.
//
// Per-player FSM
//   state    | meaning
//   S_IDLE   | no direction held; a new press gives a one-tick step
//   S_FIRST  | first step issued last tick
//   S_WAIT   | holding, counting idle ticks before auto-repeat
//   S_REPEAT | holding, stepping every tick
module paddle_move_ctrl #(
    parameter int HOLD_TICKS = 8,
    parameter int PADDLE_LEN = 20,
    parameter int DEADZONE   = 2,
    parameter int AI_DIV     = 2
) (
    input  logic       sixtyhz_clk,
    input  logic       resetn,
    input  logic [2:0] state,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       p2_ai_en,
    input  logic [6:0] ball_y,
    input  logic [6:0] paddle2_y,
    output logic       inc_p1_y,
    output logic       dec_p1_y,
    output logic       inc_p2_y,
    output logic       dec_p2_y
);

    localparam int CNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int DIV_W = (AI_DIV > 1) ? $clog2(AI_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AI_DIV - 1);
    localparam logic [7:0] HALF_LEN = 8'(PADDLE_LEN / 2);
    localparam logic [7:0] DZ       = 8'(DEADZONE);

    // Direction bits double as the {inc, dec} command: down -> inc, up -> dec.
    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_WAIT   = 2'd2,
        S_REPEAT = 2'd3
    } pstate_t;

    typedef struct packed {
        pstate_t          st;
        logic [1:0]       dir;
        logic [CNT_W-1:0] cnt;
    } pctx_t;

    localparam pctx_t IDLE_CTX = '{st: S_IDLE, dir: DIR_NONE, cnt: '0};

    pctx_t            p1_q, p1_d, p2_q, p2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ai_prev_q, ai_prev_d;
    logic [1:0]       cmd1_q, cmd1_d, cmd2_q, cmd2_d;

    logic       freeze;
    logic       ai_toggle;
    logic [1:0] p1_dir, p2_dir;
    logic [7:0] centre;
    logic [7:0] ball8;
    logic [1:0] ai_cmd;

    assign freeze    = (state == 3'd4) || (state == 3'd5);
    assign ai_toggle = (p2_ai_en != ai_prev_q);
    // Exactly one button gives a direction; none or both decode to NONE.
    assign p1_dir    = {p1_down & ~p1_up, p1_up & ~p1_down};
    assign p2_dir    = {p2_down & ~p2_up, p2_up & ~p2_down};

    // Tracker compares run at 8 bits so a centre past 127 does not wrap.
    assign ball8  = {1'b0, ball_y};
    assign centre = {1'b0, paddle2_y} + HALF_LEN;
    assign ai_cmd = {ball8 > (centre + DZ), (ball8 + DZ) < centre};

    function automatic pctx_t ctx_next(input pctx_t cur, input logic [1:0] in_dir);
        pctx_t nxt;
        nxt = cur;
        if (cur.st == S_IDLE) begin
            if (in_dir != DIR_NONE) begin
                nxt.st  = S_FIRST;
                nxt.dir = in_dir;
                nxt.cnt = '0;
            end
        end else if (in_dir == DIR_NONE) begin
            nxt = IDLE_CTX;
        end else if (in_dir != cur.dir) begin
            nxt.st  = S_FIRST;
            nxt.dir = in_dir;
            nxt.cnt = '0;
        end else begin
            case (cur.st)
                S_FIRST: begin
                    nxt.st  = S_WAIT;
                    nxt.cnt = '0;
                end
                S_WAIT: begin
                    if (cur.cnt == CNT_LAST) nxt.st = S_REPEAT;
                    else                     nxt.cnt = cur.cnt + 1'b1;
                end
                default: nxt.st = S_REPEAT;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic [1:0] ctx_cmd(input pctx_t cur, input logic [1:0] in_dir);
        logic [1:0] cmd;
        cmd = DIR_NONE;
        if (cur.st == S_IDLE || in_dir != cur.dir) begin
            cmd = in_dir;
        end else begin
            case (cur.st)
                S_WAIT:   cmd = (cur.cnt == CNT_LAST) ? cur.dir : DIR_NONE;
                S_REPEAT: cmd = cur.dir;
                default:  cmd = DIR_NONE;
            endcase
        end
        return cmd;
    endfunction

    // State register: FSM contexts, divider, mode history and registered commands.
    always_ff @(posedge sixtyhz_clk) begin
        if (!resetn) begin
            p1_q      <= IDLE_CTX;
            p2_q      <= IDLE_CTX;
            div_q     <= '0;
            ai_prev_q <= 1'b0;
            cmd1_q    <= DIR_NONE;
            cmd2_q    <= DIR_NONE;
        end else begin
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            div_q     <= div_d;
            ai_prev_q <= ai_prev_d;
            cmd1_q    <= cmd1_d;
            cmd2_q    <= cmd2_d;
        end
    end

    // Next-state: everything holds during freeze; CPU mode parks the p2 FSM in IDLE.
    always_comb begin
        p1_d      = p1_q;
        p2_d      = p2_q;
        div_d     = div_q;
        ai_prev_d = ai_prev_q;
        if (!freeze) begin
            p1_d      = ctx_next(p1_q, p1_dir);
            ai_prev_d = p2_ai_en;
            if (p2_ai_en || ai_toggle) p2_d = IDLE_CTX;
            else                       p2_d = ctx_next(p2_q, p2_dir);
            if (ai_toggle || !p2_ai_en) div_d = '0;
            else                        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    // Output: commands for the next edge; idle during freeze and on a mode change.
    always_comb begin
        cmd1_d = DIR_NONE;
        cmd2_d = DIR_NONE;
        if (!freeze) begin
            cmd1_d = ctx_cmd(p1_q, p1_dir);
            if (ai_toggle)          cmd2_d = DIR_NONE;
            else if (p2_ai_en)      cmd2_d = (div_q == '0) ? ai_cmd : DIR_NONE;
            else                    cmd2_d = ctx_cmd(p2_q, p2_dir);
        end
    end

    assign inc_p1_y = cmd1_q[1];
    assign dec_p1_y = cmd1_q[0];
    assign inc_p2_y = cmd2_q[1];
    assign dec_p2_y = cmd2_q[0];

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Directed bench for paddle_move_ctrl (HOLD_TICKS=8, PADDLE_LEN=20, DEADZONE=2, AI_DIV=2).
// Expected words are {inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y} after each tick.
module tb_paddle_move_ctrl;

    logic       sixtyhz_clk = 1'b0;
    logic       resetn;
    logic [2:0] state;
    logic       p1_up, p1_down, p2_up, p2_down, p2_ai_en;
    logic [6:0] ball_y, paddle2_y;
    logic       inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y;

    int checks = 0;
    int errors = 0;

    paddle_move_ctrl #(
        .HOLD_TICKS(8),
        .PADDLE_LEN(20),
        .DEADZONE  (2),
        .AI_DIV    (2)
    ) dut (
        .sixtyhz_clk(sixtyhz_clk),
        .resetn     (resetn),
        .state      (state),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .p2_ai_en   (p2_ai_en),
        .ball_y     (ball_y),
        .paddle2_y  (paddle2_y),
        .inc_p1_y   (inc_p1_y),
        .dec_p1_y   (dec_p1_y),
        .inc_p2_y   (inc_p2_y),
        .dec_p2_y   (dec_p2_y)
    );

    always #5 sixtyhz_clk = ~sixtyhz_clk;

    typedef struct packed {
        logic       rst_n;
        logic [2:0] st;
        logic       u1, d1, u2, d2, ai;
        logic [6:0] by, py;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input int n, input logic rst_n, input logic [2:0] st,
                        input logic u1, input logic d1, input logic u2, input logic d2,
                        input logic ai, input logic [6:0] by, input logic [6:0] py,
                        input logic [3:0] exp);
        vec_t v;
        v = '{rst_n: rst_n, st: st, u1: u1, d1: d1, u2: u2, d2: d2, ai: ai,
              by: by, py: py, exp: exp};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string name, input int idx);
        logic [3:0] got;
        resetn    = v.rst_n;
        state     = v.st;
        p1_up     = v.u1;
        p1_down   = v.d1;
        p2_up     = v.u2;
        p2_down   = v.d2;
        p2_ai_en  = v.ai;
        ball_y    = v.by;
        paddle2_y = v.py;
        @(posedge sixtyhz_clk);
        #1;
        got = {inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s[%0d] {inc1,dec1,inc2,dec2} got %b expected %b", name, idx, got, v.exp);
        end
    endtask

    // Hand sequences: n ticks of the same inputs and expectation on player 1.
    task automatic seq(input string name, input int n, input logic rst_n, input logic [2:0] st,
                       input logic u1, input logic d1, input logic [3:0] exp);
        vec_t v;
        v = '{rst_n: rst_n, st: st, u1: u1, d1: d1, u2: 1'b0, d2: 1'b0, ai: 1'b0,
              by: 7'd0, py: 7'd0, exp: exp};
        for (int i = 0; i < n; i++) apply(v, name, i);
    endtask

    initial begin
        // reset with every button held
        push(2, 0, 3'd2, 1, 1, 1, 1, 0, 7'd0, 7'd0, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 0, 7'd0, 7'd0, 4'b0000);
        // p1 down tap / hold / repeat / release
        push(1, 1, 3'd2, 0, 1, 0, 0, 0, 7'd0, 7'd0, 4'b1000);
        push(8, 1, 3'd2, 0, 1, 0, 0, 0, 7'd0, 7'd0, 4'b0000);
        push(3, 1, 3'd2, 0, 1, 0, 0, 0, 7'd0, 7'd0, 4'b1000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 0, 7'd0, 7'd0, 4'b0000);
        // both p1 buttons
        push(3, 1, 3'd2, 1, 1, 0, 0, 0, 7'd0, 7'd0, 4'b0000);
        // p2 manual up tap, then both p2 buttons
        push(1, 1, 3'd2, 0, 0, 1, 0, 0, 7'd0, 7'd0, 4'b0001);
        push(2, 1, 3'd2, 0, 0, 1, 0, 0, 7'd0, 7'd0, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 1, 1, 0, 7'd0, 7'd0, 4'b0000);
        // CPU mode, centre 50: toggle edge, then step every second tick
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd30, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd30, 7'd40, 4'b0001);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd30, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd30, 7'd40, 4'b0001);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd30, 7'd40, 4'b0000);
        // inside deadzone; p2_down pressed but ignored
        push(2, 1, 3'd2, 0, 0, 0, 1, 1, 7'd51, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd100, 7'd40, 4'b0010);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd100, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd100, 7'd40, 4'b0010);
        // centre 130 must not wrap
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd10, 7'd120, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd10, 7'd120, 4'b0001);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd10, 7'd120, 4'b0000);
        // toggle off and back on: both edges quiet, divider restarts at a step
        push(1, 1, 3'd2, 0, 0, 0, 0, 0, 7'd10, 7'd120, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd10, 7'd120, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd10, 7'd120, 4'b0001);
        // deadzone boundaries around centre 50 (non-step tick, then step tick)
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd47, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd47, 7'd40, 4'b0001);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd48, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd48, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd52, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd52, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd53, 7'd40, 4'b0000);
        push(1, 1, 3'd2, 0, 0, 0, 0, 1, 7'd53, 7'd40, 4'b0010);
        push(1, 1, 3'd2, 0, 0, 0, 0, 0, 7'd53, 7'd40, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table", i);

        // up into REPEAT, then switch to down
        seq("up_first",    1, 1, 3'd2, 1, 0, 4'b0100);
        seq("up_wait",     8, 1, 3'd2, 1, 0, 4'b0000);
        seq("up_repeat",   2, 1, 3'd2, 1, 0, 4'b0100);
        seq("switch_down", 1, 1, 3'd2, 0, 1, 4'b1000);
        seq("switch_wait", 8, 1, 3'd2, 0, 1, 4'b0000);
        seq("switch_rep",  1, 1, 3'd2, 0, 1, 4'b1000);
        seq("release",     1, 1, 3'd2, 0, 0, 4'b0000);

        // freeze mid-WAIT with cnt=3
        seq("frz_first",   1, 1, 3'd2, 0, 1, 4'b1000);
        seq("frz_pre",     4, 1, 3'd2, 0, 1, 4'b0000);
        seq("frz_hold",    5, 1, 3'd4, 0, 1, 4'b0000);
        seq("frz_resume",  4, 1, 3'd2, 0, 1, 4'b0000);
        seq("frz_repeat",  2, 1, 3'd2, 0, 1, 4'b1000);
        // freeze while in REPEAT resumes repeating with no re-sequence
        seq("frz_rep_hold", 2, 1, 3'd5, 0, 1, 4'b0000);
        seq("frz_rep_go",   1, 1, 3'd2, 0, 1, 4'b1000);
        seq("frz_rep_rel",  1, 1, 3'd2, 0, 0, 4'b0000);
        // freeze from IDLE with a press: first step happens on resume
        seq("frz_idle",    2, 1, 3'd5, 0, 1, 4'b0000);
        seq("frz_idle_go", 1, 1, 3'd2, 0, 1, 4'b1000);
        seq("frz_idle_nx", 1, 1, 3'd2, 0, 1, 4'b0000);
        seq("frz_idle_rl", 1, 1, 3'd2, 0, 0, 4'b0000);

        // reset during freeze returns p1 to IDLE
        seq("rst_press",   1, 1, 3'd2, 0, 1, 4'b1000);
        seq("rst_frz",     1, 0, 3'd4, 0, 1, 4'b0000);
        seq("rst_after",   1, 1, 3'd2, 0, 1, 4'b1000);
        seq("rst_after2",  1, 1, 3'd2, 0, 1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
